// File: rtl/qspi_stream_scheduler.sv
// -----------------------------------------------------------------------------
// qspi_stream_scheduler
//
// Sequences the QSPI flash instruction stream for the video pipeline. The
// block owns the QSPI reader's reset, restarts the reader on every frame start,
// buffers the reader's words in a first-word-fall-through FIFO and hands them
// to the pixel pipeline over a valid/ready handshake. The reader cannot be
// stalled. If the FIFO overflows, or the reader never reaches its data phase,
// the block raises a sticky flag and parks until the next frame start.
//
// Ports
//   clk            pixel clock
//   rst_n          asynchronous active-low reset
//   frame_start    single-cycle pulse: start or restart the stream
//   err_clear      single-cycle pulse: clear sticky flags and underrun count
//   reader_rst_n   active-low reset to the QSPI reader (low = reader halted)
//   reader_active  reader is in its data phase
//   reader_valid   reader_data holds a complete word this cycle
//   reader_data    instruction word from the reader
//   instr_valid    instr_data holds a valid word
//   instr_ready    consumer accepts the word
//   instr_data     FIFO head word (zero when instr_valid is low)
//   fill_level     current FIFO occupancy
//   busy           stream is running
//   err_overflow   sticky: a word arrived while the FIFO was full
//   err_timeout    sticky: reader_active did not rise in time
//   underrun_cnt   saturating count of cycles the consumer was starved
// -----------------------------------------------------------------------------
module qspi_stream_scheduler #(
   parameter int DATA_W         = 18,
   parameter int FIFO_DEPTH     = 8,
   parameter int RST_CYCLES     = 4,
   parameter int ACTIVE_TIMEOUT = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          frame_start,
   input  logic                          err_clear,
   output logic                          reader_rst_n,
   input  logic                          reader_active,
   input  logic                          reader_valid,
   input  logic [DATA_W-1:0]             reader_data,
   output logic                          instr_valid,
   input  logic                          instr_ready,
   output logic [DATA_W-1:0]             instr_data,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          busy,
   output logic                          err_overflow,
   output logic                          err_timeout,
   output logic [7:0]                    underrun_cnt
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (RST_CYCLES > ACTIVE_TIMEOUT) ? RST_CYCLES : ACTIVE_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACTIVE_TIMEOUT - 1);
   localparam logic [PTR_W:0]   FIFO_FULL    = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_ACTIVE,
      STREAM,
      FAULT
   } state_e;

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;            // shared START / WAIT_ACTIVE counter

   logic                 reader_rst_n_q, reader_rst_n_d;

   logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       count_q, count_d;

   logic                 err_overflow_q, err_overflow_d;
   logic                 err_timeout_q, err_timeout_d;
   logic [7:0]           underrun_q, underrun_d;

   logic                 in_stream;
   logic                 push_req;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 overflow_evt;
   logic                 timeout_evt;
   logic                 underrun_evt;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timeout_evt = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (frame_start) begin
               state_d = START;
            end
         end

         START: begin
            if (frame_start) begin
               cnt_d = '0;
            end else if (cnt_q == RST_LAST) begin
               state_d = WAIT_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         WAIT_ACTIVE: begin
            if (frame_start) begin
               state_d = START;
               cnt_d   = '0;
            end else if (reader_active) begin
               // Reader entering its data phase wins over a coincident timeout.
               state_d = STREAM;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d     = FAULT;
               cnt_d       = '0;
               timeout_evt = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STREAM: begin
            if (frame_start) begin
               state_d = START;
               cnt_d   = '0;
            end else if (overflow_evt) begin
               state_d = FAULT;
            end
         end

         FAULT: begin
            if (frame_start) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      in_stream   = (state_q == STREAM);
      busy        = in_stream;
      instr_valid = in_stream && (count_q != '0);
      instr_data  = instr_valid ? mem_q[rd_ptr_q] : '0;
      // The reader reset is taken from a flop so the reader never sees a
      // decode glitch; it follows the state being entered.
      reader_rst_n_d = (state_d == WAIT_ACTIVE) || (state_d == STREAM);
   end

   // ---------------------------------------------------------------------------
   // Stream events
   // ---------------------------------------------------------------------------
   always_comb begin
      // frame_start flushes the FIFO, so it suppresses both push and pop.
      push_req     = in_stream && !frame_start && reader_valid;
      pop          = instr_valid && instr_ready && !frame_start;
      full         = (count_q == FIFO_FULL);
      // A full FIFO still accepts a word when the head leaves in the same cycle.
      overflow_evt = push_req && full && !pop;
      push         = push_req && !overflow_evt;
      underrun_evt = in_stream && instr_ready && (count_q == '0);
   end

   // ---------------------------------------------------------------------------
   // FIFO pointers and occupancy
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (state_d != STREAM) begin
         // Any state other than STREAM holds the FIFO empty.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers are PTR_W bits wide and wrap modulo FIFO_DEPTH on their own.
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: the storage array has no reset; occupancy and pointers are reset,
   // and instr_data is forced to zero while the FIFO is empty, so stale
   // contents are never observable.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= reader_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky flags and underrun counter
   // ---------------------------------------------------------------------------
   always_comb begin
      // A new error event in the same cycle as err_clear leaves the flag set.
      err_overflow_d = (err_overflow_q && !err_clear) || overflow_evt;
      err_timeout_d  = (err_timeout_q && !err_clear) || timeout_evt;

      underrun_d = err_clear ? 8'd0 : underrun_q;
      if (underrun_evt && (underrun_d != 8'hFF)) begin
         underrun_d = underrun_d + 8'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reader_rst_n_q <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         err_overflow_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         underrun_q     <= '0;
      end else begin
         reader_rst_n_q <= reader_rst_n_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         err_overflow_q <= err_overflow_d;
         err_timeout_q  <= err_timeout_d;
         underrun_q     <= underrun_d;
      end
   end

   assign reader_rst_n = reader_rst_n_q;
   assign fill_level   = count_q;
   assign err_overflow = err_overflow_q;
   assign err_timeout  = err_timeout_q;
   assign underrun_cnt = underrun_q;

endmodule

// File: doc/qspi_stream_scheduler.md
Name: qspi_stream_scheduler

Overview:
- Sequences the QSPI flash instruction stream for the video pipeline.
- Owns the QSPI reader's reset/enable and restarts the stream on every frame start.
- Buffers 18-bit instruction words from the reader in a first-word-fall-through FIFO and presents them to the pixel pipeline with a valid/ready handshake.
- The reader cannot be stalled, so the block detects overflow and startup timeout, flags them, and parks until the next frame.

Parameters:
- DATA_W, 18, instruction word width.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- RST_CYCLES, 4, cycles the reader is held in reset on (re)start; at least 1.
- ACTIVE_TIMEOUT, 64, cycles allowed after reset release for reader_active to rise.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse, start or restart the stream.
- err_clear  in  1  single-cycle pulse, clears sticky error flags.
- reader_rst_n  out  1  drives the QSPI reader's active-low reset; low means reader halted.
- reader_active  in  1  reader is in its data phase.
- reader_valid  in  1  reader_data holds a complete word this cycle.
- reader_data  in  DATA_W  instruction word from the reader.
- instr_valid  out  1  instr_data is valid.
- instr_ready  in  1  consumer accepts the word.
- instr_data  out  DATA_W  FIFO head word.
- fill_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  high when state is STREAM.
- err_overflow  out  1  sticky flag.
- err_timeout  out  1  sticky flag.
- underrun_cnt  out  8  saturating count of starved cycles.

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE.
  - reader_rst_n = 0.
  - FIFO empty, fill_level = 0, instr_valid = 0, instr_data = 0.
  - err_overflow = 0, err_timeout = 0, underrun_cnt = 0, busy = 0, all counters 0.
- IDLE:
  - reader_rst_n = 0.
  - On frame_start go to START.
- START:
  - reader_rst_n = 0 and the FIFO is flushed.
  - The cycle counter runs 0..RST_CYCLES-1, then the block goes to WAIT_ACTIVE with reader_rst_n = 1 from that cycle on.
  - frame_start here restarts the counter at 0.
- WAIT_ACTIVE:
  - The timeout counter increments each cycle.
  - reader_active = 1 goes to STREAM; this takes priority if it coincides with the timeout.
  - When the counter reaches ACTIVE_TIMEOUT-1, set err_timeout and go to FAULT.
  - frame_start goes to START.
- STREAM:
  - busy = 1.
  - reader_valid pushes reader_data. The word appears at instr_data and fill_level on the next cycle, so push-to-valid latency is 1.
  - Pop occurs when instr_valid and instr_ready are both high; the next head appears on the following cycle.
  - Push and pop in the same cycle: both happen and fill_level is unchanged. This is legal when full, and when empty the push wins with no pop.
  - Push while full with no pop: the word is dropped, err_overflow is set, and the block goes to FAULT.
  - instr_ready = 1 with the FIFO empty: underrun_cnt increments, saturating at 255.
  - frame_start goes to START (flush and restart). frame_start has priority over a same-cycle push.
- FAULT:
  - reader_rst_n = 0, FIFO flushed, instr_valid = 0.
  - On frame_start go to START.
- Outside STREAM:
  - instr_valid = 0.
  - reader_valid is ignored.
  - underrun_cnt does not count.
- err_clear:
  - Clears err_overflow, err_timeout and underrun_cnt.
  - If it coincides with a new error event, the set wins.
- FIFO pointers wrap modulo FIFO_DEPTH. fill_level equals FIFO_DEPTH exactly when full.
- There is no synchronous reset path.
- rst_n assertion mid-stream returns all state to reset values immediately, without waiting for a clock.

Test Plan:
- Startup: reset, then frame_start; reader_active rises 3 cycles after release, with words 0x00001, 0x00002, 0x00003 on reader_valid and instr_ready = 1 → reader_rst_n stays low for 4 cycles, busy = 1, and the words arrive in order, each 1 cycle after its push.
- Backpressure: instr_ready = 0 and 8 pushes → fill_level = 8. A 9th push → err_overflow = 1, state FAULT, reader_rst_n = 0, instr_valid = 0.
- Full with simultaneous push and pop: at fill_level = 8 push 0x3FFFF while popping → no error, fill_level stays 8, and 0x3FFFF is delivered 8th.
- Timeout: reader_active held at 0 after release → err_timeout = 1 after 64 cycles, then FAULT. A following frame_start restarts the stream, and err_clear clears the flag.
- Mid-stream restart: frame_start with fill_level = 5 → next cycle fill_level = 0 and reader_rst_n = 0 for 4 cycles, and a same-cycle push is discarded.
- Underrun and async reset: instr_ready = 1 with an empty FIFO for 300 cycles → underrun_cnt = 255. rst_n pulsed low between clock edges → all outputs return to reset values immediately.
